// File: rtl/addr_decoder_seq_if.sv
// Request/response bundle between the arbiter and the switch-fabric address decoder.
// The master drives the request side and abort; the slave returns ready and the port select.
interface addr_decoder_seq_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned HOLD_W = 8
);
    localparam int unsigned OUT_W = 2 ** ADDR_W;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic              in_gray;
    logic [HOLD_W-1:0] in_hold;
    logic              abort;
    logic [OUT_W-1:0]  out_sel;
    logic [ADDR_W-1:0] out_index;
    logic              out_valid;

    modport master (
        output in_valid, in_addr, in_gray, in_hold, abort,
        input  in_ready, out_sel, out_index, out_valid
    );

    modport slave (
        input  in_valid, in_addr, in_gray, in_hold, abort,
        output in_ready, out_sel, out_index, out_valid
    );
endinterface

// File: rtl/addr_decoder_seq.sv
// Registered binary/Gray address decoder for the switch fabric.
// Drives a one-hot column select for a programmable slot length, then releases it.
module addr_decoder_seq #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned HOLD_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    addr_decoder_seq_if.slave  bus
);
    localparam int unsigned OUT_W = 2 ** ADDR_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SLOT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] rem_q, rem_d;
    logic [OUT_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              valid_q, valid_d;

    logic              last_c;
    logic              ready_c;
    logic              accept_c;
    logic [ADDR_W-1:0] bin_c;
    logic [HOLD_W-1:0] hold_c;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ADDR_W-1:0] gray2bin(input logic [ADDR_W-1:0] g);
        logic [ADDR_W-1:0] b;
        b[ADDR_W-1] = g[ADDR_W-1];
        for (int i = int'(ADDR_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign last_c   = (rem_q == HOLD_W'(1));
    assign ready_c  = ((state_q == S_IDLE) || last_c) && !bus.abort;
    assign accept_c = bus.in_valid && ready_c;
    assign bin_c    = bus.in_gray ? gray2bin(bus.in_addr) : bus.in_addr;
    assign hold_c   = (bus.in_hold == '0) ? HOLD_W'(1) : bus.in_hold;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            sel_q   <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            index_q <= index_d;
            valid_q <= valid_d;
        end
    end

    // Next state: abort dominates, an accept on the last slot cycle chains straight into a new slot
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else if (accept_c) begin
            state_d = S_SLOT;
        end else if ((state_q == S_SLOT) && last_c) begin
            state_d = S_IDLE;
        end
    end

    // Next values of the slot counter and the registered select outputs
    always_comb begin
        rem_d   = rem_q;
        sel_d   = sel_q;
        index_d = index_q;
        valid_d = valid_q;
        if (bus.abort) begin
            rem_d   = '0;
            sel_d   = '0;
            index_d = '0;
            valid_d = 1'b0;
        end else if (accept_c) begin
            rem_d   = hold_c;
            sel_d   = OUT_W'(1) << bin_c;
            index_d = bin_c;
            valid_d = 1'b1;
        end else if (state_q == S_SLOT) begin
            if (last_c) begin
                rem_d   = '0;
                sel_d   = '0;
                index_d = '0;
                valid_d = 1'b0;
            end else begin
                rem_d = rem_q - HOLD_W'(1);
            end
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_sel   = sel_q;
    assign bus.out_index = index_q;
    assign bus.out_valid = valid_q;
endmodule
